// File: rtl/qam_pkg.sv
// qam_pkg: shared types and constants for the QAM symbol scheduler.
// Holds the scheduler state encoding and generator/symbol defaults.
package qam_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_STALL = 2'd2
    } state_e;

    // Generator emits one new bit after this many enable rises.
    localparam int GEN_RISES_PER_BIT = 512;

    localparam int DEF_BITS_PER_SYM = 2;

endpackage

// File: rtl/qam_en_strobe.sv
// qam_en_strobe: square-wave enable strobe for the bit generator.
// Ports: clock/reset, run_i (strobe active), hold_i (force low, freeze
// phase), en_o (generator enable), rise_next_o (en_o rises next cycle).
module qam_en_strobe #(
    parameter int HALF_PERIOD = 1
) (
    input  logic clock,
    input  logic reset,
    input  logic run_i,
    input  logic hold_i,
    output logic en_o,
    output logic rise_next_o
);

    localparam int CW = $clog2(HALF_PERIOD + 1);
    localparam logic [CW-1:0] LAST = CW'(HALF_PERIOD - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          en_q, en_d;
    logic          at_last;

    assign at_last     = (cnt_q == LAST);
    assign rise_next_o = run_i && !en_q && at_last;
    assign en_o        = en_q;

    always_comb begin
        cnt_d = cnt_q;
        en_d  = en_q;
        if (!run_i) begin
            cnt_d = '0;
            en_d  = 1'b0;
        end else if (hold_i) begin
            // Phase stays parked on the suppressed rise.
            en_d = 1'b0;
        end else if (at_last) begin
            cnt_d = '0;
            en_d  = !en_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            en_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            en_q  <= en_d;
        end
    end

endmodule

// File: rtl/qam_sym_sched.sv
// qam_sym_sched: paces the bit generator, packs captured bits into
// symbols and hands them to the QAM mapper over valid/ready.
// Ports: clock, reset (async, active-low), start/stop pulses,
// gen_enable/gen_bit/gen_change to the generator, sym_data/sym_valid/
// sym_ready to the mapper, busy status, sym_count delivered symbols.
module qam_sym_sched
    import qam_pkg::*;
#(
    parameter int BITS_PER_SYM = DEF_BITS_PER_SYM,
    parameter int HALF_PERIOD  = 1,
    parameter int SYM_CNT_W    = 16
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    stop,
    output logic                    gen_enable,
    input  logic                    gen_bit,
    input  logic                    gen_change,
    output logic [BITS_PER_SYM-1:0] sym_data,
    output logic                    sym_valid,
    input  logic                    sym_ready,
    output logic                    busy,
    output logic [SYM_CNT_W-1:0]    sym_count
);

    localparam logic [3:0] NBITS = 4'(BITS_PER_SYM);

    state_e state_q, state_d;

    logic [BITS_PER_SYM-1:0] asm_q, asm_d, asm_c, ld_val;
    logic [3:0]              bcnt_q, bcnt_d;
    logic [BITS_PER_SYM-1:0] dat_q, dat_d;
    logic                    vld_q, vld_d;
    logic [SYM_CNT_W-1:0]    scnt_q, scnt_d;
    logic                    ovf_q, ovf_d;

    logic capture, out_free, xfer, full_q, load;
    logic strobe_run, strobe_hold, rise_next;

    assign capture  = gen_change && (state_q != S_IDLE) && !stop;
    assign out_free = !vld_q || sym_ready;
    assign xfer     = vld_q && sym_ready;
    assign full_q   = (bcnt_q == NBITS);
    assign asm_c    = (asm_q << 1) | BITS_PER_SYM'(gen_bit);

    qam_en_strobe #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_strobe (
        .clock       (clock),
        .reset       (reset),
        .run_i       (strobe_run),
        .hold_i      (strobe_hold),
        .en_o        (gen_enable),
        .rise_next_o (rise_next)
    );

    // Assembler: a full assembler drains first so a new bit can land
    // in the emptied one; the completing bit loads straight through.
    always_comb begin
        asm_d  = asm_q;
        bcnt_d = bcnt_q;
        ovf_d  = ovf_q;
        load   = 1'b0;
        ld_val = asm_q;
        if (full_q) begin
            if (out_free) begin
                load   = 1'b1;
                asm_d  = capture ? BITS_PER_SYM'(gen_bit) : '0;
                bcnt_d = capture ? 4'd1 : 4'd0;
            end else if (capture) begin
                ovf_d = 1'b1;
            end
        end else if (capture) begin
            if ((bcnt_q + 4'd1 == NBITS) && out_free) begin
                load   = 1'b1;
                ld_val = asm_c;
                asm_d  = '0;
                bcnt_d = 4'd0;
            end else begin
                asm_d  = asm_c;
                bcnt_d = bcnt_q + 4'd1;
            end
        end
        if (stop) begin
            asm_d  = '0;
            bcnt_d = 4'd0;
        end
    end

    always_comb begin
        vld_d  = load ? 1'b1 : (xfer ? 1'b0 : vld_q);
        dat_d  = load ? ld_val : dat_q;
        scnt_d = scnt_q + SYM_CNT_W'(xfer);
    end

    // Stall looks at the post-cycle bit count so a bit captured in
    // the same cycle as the rise decision is already accounted for.
    always_comb begin
        state_d     = state_q;
        strobe_hold = 1'b0;
        strobe_run  = (state_q != S_IDLE) && !stop;
        unique case (state_q)
            S_IDLE: begin
                if (start && !stop) state_d = S_RUN;
            end
            S_RUN: begin
                if (stop) begin
                    state_d = S_IDLE;
                end else if (rise_next && bcnt_d == NBITS) begin
                    state_d     = S_STALL;
                    strobe_hold = 1'b1;
                end
            end
            S_STALL: begin
                if (stop) state_d = S_IDLE;
                else if (sym_ready) state_d = S_RUN;
                else strobe_hold = 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            asm_q   <= '0;
            bcnt_q  <= 4'd0;
            dat_q   <= '0;
            vld_q   <= 1'b0;
            scnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            asm_q   <= asm_d;
            bcnt_q  <= bcnt_d;
            dat_q   <= dat_d;
            vld_q   <= vld_d;
            scnt_q  <= scnt_d;
            ovf_q   <= ovf_d;
        end
    end

    assign sym_data  = dat_q;
    assign sym_valid = vld_q;
    assign busy      = (state_q != S_IDLE);
    assign sym_count = scnt_q;

    // A bit arriving into a full, undrainable assembler would be lost.
    a_no_overflow: assert property (
        @(posedge clock) disable iff (!reset) !ovf_q
    );

endmodule

// File: doc/qam_sym_sched.md
Name: qam_sym_sched

Overview:
- Sequencer between the bit-pattern data generator and the QAM mapper.
- Drives the generator's enable strobe with a programmable square wave and captures one bit on every generator bit-change pulse.
- Packs BITS_PER_SYM bits into a symbol and hands it to the mapper over a valid/ready handshake.
- Throttles the generator, by freezing enable, when the downstream consumer backpressures, so no bit is ever dropped.

Parameters:
- BITS_PER_SYM, 2: bits per symbol (2 = I/Q pair for 4-QAM); range 1..8.
- HALF_PERIOD, 1: clock cycles gen_enable stays low and then high per strobe period; must be >= 1.
- SYM_CNT_W, 16: width of the delivered-symbol counter.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; IDLE -> RUN.
- stop  in  1  single-cycle pulse; any state -> IDLE; stop wins over start in the same cycle.
- gen_enable  out  1  to generator enable input; each 0->1 edge is one generator count.
- gen_bit  in  1  generator serial data output.
- gen_change  in  1  generator one-cycle pulse; gen_bit already holds the new bit in this cycle.
- sym_data  out  BITS_PER_SYM  symbol; first captured bit in the MSB.
- sym_valid  out  1  sym_data holds an undelivered symbol.
- sym_ready  in  1  consumer accepts; transfer when sym_valid && sym_ready.
- busy  out  1  high in RUN and STALL.
- sym_count  out  SYM_CNT_W  delivered-symbol count; wraps modulo 2^SYM_CNT_W.

Behaviour:
- Reset (reset=0, async): state=IDLE. gen_enable=0, sym_valid=0, sym_data=0, busy=0, sym_count=0. Assembler bit count=0, half-period counter=0.
- Asserting reset mid-operation discards the partial symbol and the held symbol.
- States:
  - IDLE: gen_enable=0. start -> RUN.
  - RUN: gen_enable toggles every HALF_PERIOD cycles, starting low. Period = 2*HALF_PERIOD cycles.
  - STALL: gen_enable held 0, half-period counter frozen.
- RUN -> STALL: only at a scheduled low->high transition, and only when the assembler holds BITS_PER_SYM bits and the output register is full with no sym_ready this cycle. The rise is suppressed.
- STALL -> RUN: in the cycle the output register frees. The suppressed rise is issued the next cycle.
- Capture: on gen_change=1 in RUN or STALL, shift gen_bit into the assembler LSB and increment the bit count.
  - gen_change in IDLE is ignored.
  - A gen_change arriving when the assembler is already full is a protocol error: hold it in a sticky internal flag for assertions; no port.
- Load: when bit count == BITS_PER_SYM and (sym_valid==0 or sym_ready==1), move the assembler to sym_data, set sym_valid=1 and clear the bit count, all in one cycle.
  - Capture into an emptied assembler may happen in the same cycle as the load.
- Latency: last gen_change -> sym_valid=1 in 1 cycle when the output register is free.
- Handshake:
  - sym_data is stable while sym_valid && !sym_ready.
  - sym_valid drops the cycle after transfer unless a new load happens in the same cycle.
  - sym_count increments on each transfer.
- stop:
  - gen_enable=0 next cycle; partial assembler bits are cleared.
  - A held symbol stays valid until consumed.
  - The generator's internal count position is not touched.
- Safety argument: a generator bit arrives 1 cycle after the 512th rise. With HALF_PERIOD >= 1 the next rise is >= 2 cycles later, so the stall decision always sees the updated bit count.

Decomposition:
- Shared package qam_pkg: state encoding (IDLE, RUN, STALL), GEN_RISES_PER_BIT=512, default BITS_PER_SYM.
- One sub-module qam_en_strobe: HALF_PERIOD counter plus toggle, with inputs run/hold, output gen_enable and a rise_next flag.
- The FSM, assembler and output register stay in the top level.

Test Plan:
- Generator model (28-bit pattern 0x6CC1555, MSB out, shifts every 512 rises), HALF_PERIOD=1, sym_ready=1, start -> first three symbols 2'b11, 2'b01, 2'b10. First sym_valid ~2050 cycles after start; sym_count=3 after the third.
- Full 14-symbol cycle, sym_ready=1 -> sequence 11,01,10,01,10,00,00,10,10,10,10,10,10,10 then repeats; sym_count=14.
- sym_ready=0 after symbol 1 -> second symbol assembled, gen_enable stuck 0 (STALL), no further gen_change, sym_data=2'b11 stable. Raise sym_ready -> 11 then 01 delivered, no bit lost.
- stop after one captured bit -> gen_enable=0 next cycle, busy=0, partial bit dropped. Restart -> next symbol is built from fresh bits only.
- Assert reset mid-RUN with sym_valid=1 -> immediately sym_valid=0, gen_enable=0, sym_count=0, state IDLE.
- start and stop in the same cycle from IDLE -> stays IDLE, gen_enable=0.
